// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two single-cycle pipes and a FIFO-buffered
// long-latency unit onto register-file write ports 3 and 6 (registered outputs).
module wb_arbiter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       p0_we,
   input  logic [4:0]                 p0_rd,
   input  logic [XLEN-1:0]            p0_wd,
   input  logic                       p1_we,
   input  logic [4:0]                 p1_rd,
   input  logic [XLEN-1:0]            p1_wd,
   input  logic                       ll_valid,
   input  logic [4:0]                 ll_rd,
   input  logic [XLEN-1:0]            ll_wd,
   output logic                       ll_ready,
   output logic                       we3,
   output logic [4:0]                 a3,
   output logic [XLEN-1:0]            wd3,
   output logic                       we6,
   output logic [4:0]                 a6,
   output logic [XLEN-1:0]            wd6,
   output logic [$clog2(DEPTH):0]     ll_count,
   output logic                       ll_drop
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]      mem_rd [DEPTH];
   logic [XLEN-1:0] mem_wd [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   logic            v0, v1, head_v, stale, push, pop;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_wd;
   logic            g3_v, g6_v;
   logic [4:0]      g3_a, g6_a;
   logic [XLEN-1:0] g3_d, g6_d;

   assign ll_ready = !reset && (count != CW'(DEPTH));
   assign ll_count = count;
   assign head_v   = (count != '0);
   assign head_rd  = mem_rd[rd_ptr];
   assign head_wd  = mem_wd[rd_ptr];

   always_comb begin
      v0    = p0_we && (p0_rd != '0);
      v1    = p1_we && (p1_rd != '0);
      // rd==0 results are accepted to keep the handshake flowing but never stored
      push  = ll_valid && ll_ready && (ll_rd != '0);
      stale = head_v && ((v0 && head_rd == p0_rd) || (v1 && head_rd == p1_rd));
      pop   = head_v && (stale || !(v0 && v1));
      g3_v  = 1'b0;
      g3_a  = '0;
      g3_d  = '0;
      g6_v  = 1'b0;
      g6_a  = '0;
      g6_d  = '0;
      if (v0) begin
         g3_v = 1'b1;
         g3_a = p0_rd;
         g3_d = p0_wd;
      end else if (v1) begin
         g3_v = 1'b1;
         g3_a = p1_rd;
         g3_d = p1_wd;
      end else if (head_v && !stale) begin
         g3_v = 1'b1;
         g3_a = head_rd;
         g3_d = head_wd;
      end
      if (v0 && v1) begin
         g6_v = 1'b1;
         g6_a = p1_rd;
         g6_d = p1_wd;
      end else if ((v0 ^ v1) && head_v && !stale) begin
         g6_v = 1'b1;
         g6_a = head_rd;
         g6_d = head_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_rd[wr_ptr] <= ll_rd;
         mem_wd[wr_ptr] <= ll_wd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         we3     <= 1'b0;
         a3      <= '0;
         wd3     <= '0;
         we6     <= 1'b0;
         a6      <= '0;
         wd6     <= '0;
         ll_drop <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count + CW'(push) - CW'(pop);
         ll_drop <= stale;
         we3     <= g3_v;
         we6     <= g6_v;
         if (g3_v) begin
            a3  <= g3_a;
            wd3 <= g3_d;
         end
         if (g6_v) begin
            a6  <= g6_a;
            wd6 <= g6_d;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, XLEN=32).
module tb_wb_arbiter;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            p0_we, p1_we, ll_valid;
   logic [4:0]      p0_rd, p1_rd, ll_rd;
   logic [XLEN-1:0] p0_wd, p1_wd, ll_wd;
   logic            ll_ready, we3, we6, ll_drop;
   logic [4:0]      a3, a6;
   logic [XLEN-1:0] wd3, wd6;
   logic [2:0]      ll_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .p0_we(p0_we), .p0_rd(p0_rd), .p0_wd(p0_wd),
      .p1_we(p1_we), .p1_rd(p1_rd), .p1_wd(p1_wd),
      .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_wd(ll_wd), .ll_ready(ll_ready),
      .we3(we3), .a3(a3), .wd3(wd3),
      .we6(we6), .a6(a6), .wd6(wd6),
      .ll_count(ll_count), .ll_drop(ll_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p0_we = 1'b0; p0_rd = '0; p0_wd = '0;
      p1_we = 1'b0; p1_rd = '0; p1_wd = '0;
      ll_valid = 1'b0; ll_rd = '0; ll_wd = '0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick(); tick();
      // 1: reset state, then dual pipe writes
      check("rst_we3", 32'(we3), 32'd0);
      check("rst_we6", 32'(we6), 32'd0);
      check("rst_a3", 32'(a3), 32'd0);
      check("rst_wd6", wd6, 32'd0);
      check("rst_cnt", 32'(ll_count), 32'd0);
      check("rst_rdy", 32'(ll_ready), 32'd0);
      check("rst_drop", 32'(ll_drop), 32'd0);
      reset = 1'b0;
      #1;
      check("rel_rdy", 32'(ll_ready), 32'd1);
      p0_we = 1'b1; p0_rd = 5'd5; p0_wd = 32'hA;
      p1_we = 1'b1; p1_rd = 5'd6; p1_wd = 32'hB;
      tick();
      check("t1_we3", 32'(we3), 32'd1);
      check("t1_a3", 32'(a3), 32'd5);
      check("t1_wd3", wd3, 32'hA);
      check("t1_we6", 32'(we6), 32'd1);
      check("t1_a6", 32'(a6), 32'd6);
      check("t1_wd6", wd6, 32'hB);
      check("t1_cnt", 32'(ll_count), 32'd0);

      // 2: single long-latency push, two-cycle latency
      idle();
      ll_valid = 1'b1; ll_rd = 5'd7; ll_wd = 32'h77;
      tick();
      idle();
      check("t2_cnt1", 32'(ll_count), 32'd1);
      check("t2_we3_early", 32'(we3), 32'd0);
      tick();
      check("t2_we3", 32'(we3), 32'd1);
      check("t2_a3", 32'(a3), 32'd7);
      check("t2_wd3", wd3, 32'h77);
      check("t2_we6", 32'(we6), 32'd0);
      check("t2_cnt0", 32'(ll_count), 32'd0);

      // 3: fill under full pipe traffic, then drain through port 6
      p0_we = 1'b1; p0_rd = 5'd1; p0_wd = 32'h11;
      p1_we = 1'b1; p1_rd = 5'd2; p1_wd = 32'h22;
      for (int i = 0; i < 4; i++) begin
         ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_wd = 32'h100 + 32'(i);
         tick();
         check("t3_fill_cnt", 32'(ll_count), 32'(i + 1));
         check("t3_fill_a6", 32'(a6), 32'd2);
      end
      check("t3_full_rdy", 32'(ll_ready), 32'd0);
      ll_rd = 5'd14; ll_wd = 32'h104;
      tick();
      check("t3_full_cnt", 32'(ll_count), 32'd4);
      ll_valid = 1'b0;
      p1_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_drain_we6", 32'(we6), 32'd1);
         check("t3_drain_a6", 32'(a6), 32'(10 + i));
         check("t3_drain_wd6", wd6, 32'h100 + 32'(i));
         check("t3_drain_a3", 32'(a3), 32'd1);
         check("t3_drain_cnt", 32'(ll_count), 32'(3 - i));
      end
      idle();
      tick();
      check("t3_idle_we3", 32'(we3), 32'd0);
      check("t3_idle_we6", 32'(we6), 32'd0);
      check("t3_hold_a3", 32'(a3), 32'd1);
      check("t3_hold_wd6", wd6, 32'h103);

      // 4: stale head discarded
      ll_valid = 1'b1; ll_rd = 5'd9; ll_wd = 32'h99;
      tick();
      idle();
      p0_we = 1'b1; p0_rd = 5'd9; p0_wd = 32'h55;
      tick();
      idle();
      check("t4_drop", 32'(ll_drop), 32'd1);
      check("t4_a3", 32'(a3), 32'd9);
      check("t4_wd3", wd3, 32'h55);
      check("t4_we6", 32'(we6), 32'd0);
      check("t4_cnt", 32'(ll_count), 32'd0);
      tick();
      check("t4_drop_clr", 32'(ll_drop), 32'd0);
      check("t4_no_late", 32'(we3), 32'd0);

      // 5: rd==0 pipe requests ignored, head takes port 3
      ll_valid = 1'b1; ll_rd = 5'd3; ll_wd = 32'h33;
      tick();
      idle();
      p0_we = 1'b1; p0_rd = 5'd0; p0_wd = 32'hDEAD;
      p1_we = 1'b1; p1_rd = 5'd0; p1_wd = 32'hBEEF;
      tick();
      idle();
      check("t5_we3", 32'(we3), 32'd1);
      check("t5_a3", 32'(a3), 32'd3);
      check("t5_wd3", wd3, 32'h33);
      check("t5_we6", 32'(we6), 32'd0);

      // 6: reset mid-drain
      p0_we = 1'b1; p0_rd = 5'd1; p0_wd = 32'h11;
      p1_we = 1'b1; p1_rd = 5'd2; p1_wd = 32'h22;
      for (int i = 0; i < 4; i++) begin
         ll_valid = 1'b1; ll_rd = 5'(20 + i); ll_wd = 32'h200 + 32'(i);
         tick();
      end
      ll_valid = 1'b0;
      p1_we = 1'b0;
      tick();
      check("t6_pre_cnt", 32'(ll_count), 32'd3);
      check("t6_pre_a6", 32'(a6), 32'd20);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_we3", 32'(we3), 32'd0);
      check("t6_async_we6", 32'(we6), 32'd0);
      check("t6_async_cnt", 32'(ll_count), 32'd0);
      check("t6_async_rdy", 32'(ll_ready), 32'd0);
      idle();
      tick();
      check("t6_hold_rdy", 32'(ll_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("t6_rel_rdy", 32'(ll_ready), 32'd1);
      tick();
      check("t6_post_we3", 32'(we3), 32'd0);
      check("t6_post_we6", 32'(we6), 32'd0);
      check("t6_post_cnt", 32'(ll_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
